fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 16'h0000, PC value loaded after reset.
REQ-002 Parameter FLUSH_CYCLES, 2, pc_inv cycles after any PC load (range 1..7).
REQ-003 One clock; reset is asynchronous and active-low; ports are clk and a_rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 a_rst  in  1  async active-low reset.
REQ-006 ir_valid  in  1  fetch unit holds a valid instruction.
REQ-007 dec_len2  in  1  current instruction carries a k16 word (advance by 2 words).
REQ-008 stall_req  in  1  backend cannot accept an instruction.
REQ-009 br_taken  in  1  current issued instruction redirects the PC.
REQ-010 br_target  in  16  redirect target address.
REQ-011 pc_w  out  1  load the fetch PC from pc_alu.
REQ-012 pc_alu  out  16  PC load value.
REQ-013 pc_inc  out  1  advance the fetch PC.
REQ-014 pc_i2  out  1  qualifies pc_inc as a 2-word advance.
REQ-015 pc_inv  out  1  invalidate the IR/prefetch contents.
REQ-016 hold  out  1  freeze the fetch unit.
REQ-017 issue_valid  out  1  instruction handed to the backend this cycle.
REQ-018 redirect_cnt  out  8  count of redirects since reset, wraps.

Function
REQ-019 States SHALL be INIT, FLUSH, RUN, STALL, REDIRECT.
REQ-020 INIT: pc_w=1, pc_alu=RESET_VECTOR, pc_inv=1, hold=0; next state FLUSH.
REQ-021 FLUSH: pc_inv=1, pc_w=0, pc_inc=0; flush counter loads FLUSH_CYCLES on entry and decrements each cycle; at 1 -> STALL if stall_req, else RUN; stall_req does not extend FLUSH.
REQ-022 RUN: issue_valid = ir_valid & ~stall_req (combinational); pc_inc = issue_valid; pc_i2 = issue_valid & dec_len2; hold = stall_req (combinational).
REQ-023 RUN with issue_valid & br_taken: latch br_target; next state REDIRECT; pc_inc/pc_i2 still asserted that cycle.
REQ-024 RUN with stall_req=1 -> STALL; br_taken ignored when issue_valid=0.
REQ-025 STALL: hold=1, pc_inc=pc_i2=issue_valid=0; stall_req=0 -> RUN, else stay.
REQ-026 REDIRECT: pc_w=1, pc_alu=latched target, pc_inv=1, hold=0; redirect_cnt increments (8'hFF wraps to 8'h00); next state FLUSH.
REQ-027 Branch latency: br_taken issued in cycle N -> pc_w in N+1 -> FLUSH N+2..N+1+FLUSH_CYCLES -> first possible issue N+2+FLUSH_CYCLES.
REQ-028 pc_alu SHALL hold its last driven value in states other than INIT and REDIRECT; pc_w SHALL be asserted only in INIT and REDIRECT.
REQ-029 pc_i2 SHALL never assert without pc_inc; pc_inc SHALL never assert alongside pc_w or pc_inv.
REQ-030 PC arithmetic belongs to the fetch unit; no wrap handling is required here, a target of 16'hFFFE SHALL pass through unchanged.

Reset
REQ-031 a_rst low SHALL force INIT immediately, mid-operation included; latched target clears to RESET_VECTOR, flush counter to 0, redirect_cnt to 0.
REQ-032 Outputs during reset: pc_w=1, pc_alu=RESET_VECTOR, pc_inv=1, hold=0, pc_inc=0, pc_i2=0, issue_valid=0, redirect_cnt=0.

Structure
REQ-033 State enumeration and default RESET_VECTOR/FLUSH_CYCLES SHALL live in shared package fe_pkg, also used by fetch_unit.
REQ-034 Single module; no sub-module is natural; flush counter, target register and redirect counter are inline.

Verification
REQ-035 Reset release, ir_valid=1, no stall -> pc_w one cycle with pc_alu=16'h0000, pc_inv 2 cycles, first issue_valid 3 cycles after release.
REQ-036 RUN, ir_valid=1, dec_len2 alternating 0/1 -> pc_inc every cycle, pc_i2 on alternate cycles only.
REQ-037 br_taken with br_target=16'h0040 -> next cycle pc_w=1, pc_alu=16'h0040; 2 pc_inv cycles; redirect_cnt 0->1.
REQ-038 stall_req high 4 cycles in RUN -> hold same cycle, 4 cycles no pc_inc, issue resumes the cycle after stall_req falls.
REQ-039 a_rst asserted during FLUSH after redirect -> immediate INIT outputs, redirect_cnt=0, full reset sequence repeats.
REQ-040 256 redirects -> redirect_cnt wraps to 8'h00; stall_req during FLUSH -> enters STALL, not RUN.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared fetch-path definitions: sequencer states and default PC/flush settings,
// used by both the fetch sequencer and the fetch unit.
package fe_pkg;

  typedef enum logic [2:0] {
    INIT,
    FLUSH,
    RUN,
    STALL,
    REDIRECT
  } fe_state_t;

  localparam int          FE_ADDR_W       = 16;
  localparam logic [15:0] FE_RESET_VECTOR = 16'h0000;
  localparam int          FE_FLUSH_CYCLES = 2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer (master) and the fetch unit/backend (slave).
interface fetch_sequencer_if;
  import fe_pkg::*;

  logic                 ir_valid;
  logic                 dec_len2;
  logic                 stall_req;
  logic                 br_taken;
  logic [FE_ADDR_W-1:0] br_target;
  logic                 pc_w;
  logic [FE_ADDR_W-1:0] pc_alu;
  logic                 pc_inc;
  logic                 pc_i2;
  logic                 pc_inv;
  logic                 hold;
  logic                 issue_valid;
  logic [7:0]           redirect_cnt;

  modport master (
    input  ir_valid, dec_len2, stall_req, br_taken, br_target,
    output pc_w, pc_alu, pc_inc, pc_i2, pc_inv, hold, issue_valid, redirect_cnt
  );

  modport slave (
    output ir_valid, dec_len2, stall_req, br_taken, br_target,
    input  pc_w, pc_alu, pc_inc, pc_i2, pc_inv, hold, issue_valid, redirect_cnt
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC load/advance, IR invalidation and fetch hold
// through reset, branch redirects, post-load flush and backend stalls.
module fetch_sequencer
  import fe_pkg::*;
#(
  parameter logic [FE_ADDR_W-1:0] RESET_VECTOR = FE_RESET_VECTOR,
  parameter int                   FLUSH_CYCLES = FE_FLUSH_CYCLES
) (
  input  logic               clk,
  input  logic               a_rst,
  fetch_sequencer_if.master  bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  fe_state_t            state, state_nxt;
  logic [2:0]           flush_cnt;
  logic [FE_ADDR_W-1:0] tgt_q;
  logic [7:0]           redirect_cnt_q;

  logic pc_w, pc_inc, pc_i2, pc_inv, hold, issue;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state          <= INIT;
      flush_cnt      <= 3'd0;
      tgt_q          <= RESET_VECTOR;
      redirect_cnt_q <= 8'h00;
    end else begin
      state <= state_nxt;
      // FLUSH is only ever entered from INIT or REDIRECT, so load on those
      if (state == INIT || state == REDIRECT)
        flush_cnt <= FLUSH_LOAD;
      else if (state == FLUSH)
        flush_cnt <= flush_cnt - 3'd1;
      if (state == RUN && issue && bus.br_taken)
        tgt_q <= bus.br_target;
      if (state == REDIRECT)
        redirect_cnt_q <= redirect_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_w      = 1'b0;
    pc_inc    = 1'b0;
    pc_i2     = 1'b0;
    pc_inv    = 1'b0;
    hold      = 1'b0;
    issue     = 1'b0;
    case (state)
      INIT: begin
        pc_w      = 1'b1;
        pc_inv    = 1'b1;
        state_nxt = FLUSH;
      end
      FLUSH: begin
        pc_inv = 1'b1;
        if (flush_cnt <= 3'd1)
          state_nxt = bus.stall_req ? STALL : RUN;
      end
      RUN: begin
        issue  = bus.ir_valid & ~bus.stall_req;
        pc_inc = issue;
        pc_i2  = issue & bus.dec_len2;
        hold   = bus.stall_req;
        if (bus.stall_req)
          state_nxt = STALL;
        else if (issue && bus.br_taken)
          state_nxt = REDIRECT;
      end
      STALL: begin
        hold = 1'b1;
        if (!bus.stall_req)
          state_nxt = RUN;
      end
      REDIRECT: begin
        pc_w      = 1'b1;
        pc_inv    = 1'b1;
        state_nxt = FLUSH;
      end
      default: state_nxt = INIT;
    endcase
  end

  // tgt_q only changes on the edge into REDIRECT, so it doubles as the
  // held last-driven load value in every other state.
  assign bus.pc_alu       = (state == INIT) ? RESET_VECTOR : tgt_q;
  assign bus.pc_w         = pc_w;
  assign bus.pc_inc       = pc_inc;
  assign bus.pc_i2        = pc_i2;
  assign bus.pc_inv       = pc_inv;
  assign bus.hold         = hold;
  assign bus.issue_valid  = issue;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: per-cycle stimulus and expected
// outputs are queued together, then applied and compared cycle by cycle.
module tb_fetch_sequencer;

  localparam logic [15:0] RV = 16'h0000;

  typedef struct packed {
    logic [95:0] tag;
    logic        irv;
    logic        len2;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [29:0] exp;
  } cyc_t;

  logic clk = 1'b0;
  logic a_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] last_alu;
  logic [7:0]  cnt;
  cyc_t        sb[$];
  cyc_t        c;

  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {bus.pc_w, bus.pc_alu, bus.pc_inc, bus.pc_i2, bus.pc_inv,
                bus.hold, bus.issue_valid, bus.redirect_cnt};

  // Expected output vectors: {pc_w, pc_alu, pc_inc, pc_i2, pc_inv, hold, issue_valid, redirect_cnt}
  function automatic logic [29:0] o_init();
    return {1'b1, RV, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
  endfunction
  function automatic logic [29:0] o_flush(logic [15:0] alu, logic [7:0] n);
    return {1'b0, alu, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, n};
  endfunction
  function automatic logic [29:0] o_redir(logic [15:0] alu, logic [7:0] n);
    return {1'b1, alu, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, n};
  endfunction
  function automatic logic [29:0] o_run(logic [15:0] alu, logic [7:0] n,
                                        logic iv, logic i2, logic hd);
    return {1'b0, alu, iv, i2, 1'b0, hd, iv, n};
  endfunction
  function automatic logic [29:0] o_stall(logic [15:0] alu, logic [7:0] n);
    return {1'b0, alu, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n};
  endfunction

  function automatic void push(logic [95:0] tag, logic irv, logic len2, logic stall,
                               logic br, logic [15:0] tgt, logic [29:0] e);
    cyc_t x;
    x.tag = tag; x.irv = irv; x.len2 = len2; x.stall = stall;
    x.br = br; x.tgt = tgt; x.exp = e;
    sb.push_back(x);
  endfunction

  task automatic apply(cyc_t x);
    bus.ir_valid  = x.irv;
    bus.dec_len2  = x.len2;
    bus.stall_req = x.stall;
    bus.br_taken  = x.br;
    bus.br_target = x.tgt;
  endtask

  task automatic push_startup();
    push("init", 1, 0, 0, 0, 16'h0, o_init());
    push("flush_a", 1, 0, 0, 0, 16'h0, o_flush(RV, 8'h00));
    push("flush_b", 1, 0, 0, 0, 16'h0, o_flush(RV, 8'h00));
    push("first_iss", 1, 0, 0, 0, 16'h0, o_run(RV, 8'h00, 1, 0, 0));
  endtask

  task automatic test_reset();
    a_rst = 1'b0;
    bus.ir_valid = 1'b1; bus.dec_len2 = 1'b1; bus.stall_req = 1'b0;
    bus.br_taken = 1'b1; bus.br_target = 16'hBEEF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs !== o_init()) begin
        errors++;
        $display("FAIL reset_outputs got %h want %h", obs, o_init());
      end
    end
    last_alu = RV;
    cnt = 8'h00;
  endtask

  task automatic test_startup();
    @(posedge clk); #1;
    a_rst = 1'b1;
    push_startup();
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_len2_alternate();
    for (int i = 0; i < 6; i++)
      push("len2_alt", 1, 1'(i % 2), 0, 0, 16'h0, o_run(last_alu, cnt, 1, 1'(i % 2), 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    push("br_no_iss", 0, 0, 0, 1, 16'h1234, o_run(last_alu, cnt, 0, 0, 0));
    push("br_issue", 1, 1, 0, 1, 16'h0040, o_run(last_alu, cnt, 1, 1, 0));
    push("br_redir", 1, 0, 0, 0, 16'h0, o_redir(16'h0040, cnt));
    cnt = cnt + 8'd1;
    last_alu = 16'h0040;
    push("br_flush_a", 1, 0, 0, 0, 16'h0, o_flush(last_alu, cnt));
    push("br_flush_b", 1, 0, 0, 0, 16'h0, o_flush(last_alu, cnt));
    push("br_resume", 1, 0, 0, 0, 16'h0, o_run(last_alu, cnt, 1, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    push("stall_run", 1, 1, 1, 1, 16'h0200, o_run(last_alu, cnt, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      push("stall_hold", 1, 1, 1, 0, 16'h0, o_stall(last_alu, cnt));
    push("stall_fall", 1, 1, 0, 0, 16'h0, o_stall(last_alu, cnt));
    push("stall_res", 1, 1, 0, 0, 16'h0, o_run(last_alu, cnt, 1, 1, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_stall_fffe();
    push("fe_issue", 1, 0, 0, 1, 16'hFFFE, o_run(last_alu, cnt, 1, 0, 0));
    push("fe_redir", 1, 0, 0, 0, 16'h0, o_redir(16'hFFFE, cnt));
    cnt = cnt + 8'd1;
    last_alu = 16'hFFFE;
    push("fe_flush_a", 1, 0, 1, 0, 16'h0, o_flush(last_alu, cnt));
    push("fe_flush_b", 1, 0, 1, 0, 16'h0, o_flush(last_alu, cnt));
    push("fe_stall", 1, 0, 1, 0, 16'h0, o_stall(last_alu, cnt));
    push("fe_st_fall", 1, 0, 0, 0, 16'h0, o_stall(last_alu, cnt));
    push("fe_resume", 1, 0, 0, 0, 16'h0, o_run(last_alu, cnt, 1, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_flush();
    push("mr_issue", 1, 0, 0, 1, 16'h0100, o_run(last_alu, cnt, 1, 0, 0));
    push("mr_redir", 1, 0, 0, 0, 16'h0, o_redir(16'h0100, cnt));
    cnt = cnt + 8'd1;
    push("mr_flush", 1, 0, 0, 0, 16'h0, o_flush(16'h0100, cnt));
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
    // Second FLUSH cycle: assert reset between edges, outputs must react at once
    a_rst = 1'b0;
    #1;
    checks++;
    if (obs !== o_init()) begin
      errors++;
      $display("FAIL mid_flush_reset got %h want %h", obs, o_init());
    end
    cnt = 8'h00;
    last_alu = RV;
    @(posedge clk); #1;
    a_rst = 1'b1;
    push_startup();
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL re_%0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cnt_wrap();
    logic [15:0] t;
    for (int i = 0; i < 256; i++) begin
      t = 16'(i * 4);
      push("wr_issue", 1, 0, 0, 1, t, o_run(last_alu, cnt, 1, 0, 0));
      push("wr_redir", 1, 0, 0, 0, 16'h0, o_redir(t, cnt));
      cnt = cnt + 8'd1;
      last_alu = t;
      push("wr_flush_a", 1, 0, 0, 0, 16'h0, o_flush(t, cnt));
      push("wr_flush_b", 1, 0, 0, 0, 16'h0, o_flush(t, cnt));
    end
    push("wr_wrapped", 1, 0, 0, 0, 16'h0, o_run(last_alu, 8'h00, 1, 0, 0));
    while (sb.size() > 0) begin
      c = sb.pop_front(); apply(c);
      @(negedge clk); checks++;
      if (obs !== c.exp) begin errors++; $display("FAIL %0s got %h want %h", c.tag, obs, c.exp); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_len2_alternate();
    test_branch();
    test_stall();
    test_flush_stall_fffe();
    test_reset_mid_flush();
    test_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
